fetch_redirect_unit: RTL and testbench

- Front-end fetch sequencer; the consumer of the branch unit's redirect outputs (branch-taken flag plus new PC).
- Holds the fetch PC and issues in-order fetch requests to instruction memory over a valid/ready handshake.
- Buffers returned instruction words in a small FIFO and presents them, with their addresses, to decode.
- On a redirect it flushes the FIFO, discards stale in-flight responses using a 1-bit epoch tag, and restarts fetch at the target.

---
 rtl/fetch_redirect_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_redirect_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_unit.sv
// Front-end fetch sequencer: in-order fetch requests, a small instruction buffer for decode,
// and redirect handling that restarts fetch and drops stale in-flight responses.
module fetch_redirect_unit #(
    parameter int unsigned             addressWidth = 64,
    parameter logic [addressWidth-1:0] resetVector  = '0,
    parameter int unsigned             instrWidth   = 32,
    parameter int unsigned             fifoDepth    = 4
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    stall_i,
    input  logic                    isBranching_i,
    input  logic [addressWidth-1:0] branchTarget_i,
    input  logic                    is64Bit_i,
    output logic                    memReqValid_o,
    output logic [addressWidth-1:0] memReqAddr_o,
    output logic                    memReqEpoch_o,
    input  logic                    memReqReady_i,
    input  logic                    memRespValid_i,
    input  logic [instrWidth-1:0]   memRespData_i,
    input  logic                    memRespEpoch_i,
    output logic                    instrValid_o,
    output logic [instrWidth-1:0]   instruction_o,
    output logic [addressWidth-1:0] instructionAddress_o
);
    localparam int                      CW        = $clog2(fifoDepth);
    localparam logic [CW+1:0]           DepthC    = (CW+2)'(fifoDepth);
    localparam logic [addressWidth-1:0] Low32Mask = {addressWidth{1'b1}} >> (addressWidth - 32);

    function automatic logic [addressWidth-1:0] maskPc(input logic [addressWidth-1:0] pc,
                                                       input logic wide);
        return wide ? pc : (pc & Low32Mask);
    endfunction

    logic [addressWidth-1:0] fetchPC_q, fetchPC_d;
    logic                    epoch_q, epoch_d;
    logic                    drainOld_q, drainOld_d;
    logic [CW:0]             outstanding_q, outstanding_d;
    logic [CW:0]             fifoCount_q, fifoCount_d;
    logic [CW-1:0]           fifoRd_q, fifoRd_d, fifoWr_q, fifoWr_d;
    logic [CW-1:0]           aqRd_q, aqRd_d, aqWr_q, aqWr_d;

    logic [instrWidth-1:0]   fifoData_q [fifoDepth];
    logic [addressWidth-1:0] fifoAddr_q [fifoDepth];
    logic [addressWidth-1:0] aq_q       [fifoDepth];

    logic [CW+1:0] inFlight;
    logic          reqValid, accept, respTake, push, pop;

    assign inFlight = {1'b0, outstanding_q} + {1'b0, fifoCount_q};
    // While old-epoch responses drain after a redirect, new requests would alias the epoch bit.
    assign reqValid = !reset_i && !isBranching_i && (inFlight < DepthC)
                    && !(drainOld_q && (outstanding_q != '0));
    assign accept   = reqValid && memReqReady_i;
    assign respTake = memRespValid_i && (outstanding_q != '0);
    assign push     = respTake && (memRespEpoch_i == epoch_q) && !drainOld_q && !isBranching_i;
    assign pop      = (fifoCount_q != '0) && !stall_i;

    always_comb begin
        fetchPC_d     = fetchPC_q;
        epoch_d       = epoch_q;
        drainOld_d    = drainOld_q;
        outstanding_d = outstanding_q;
        fifoCount_d   = fifoCount_q;
        fifoRd_d      = fifoRd_q;
        fifoWr_d      = fifoWr_q;
        aqRd_d        = respTake ? aqRd_q + 1'b1 : aqRd_q;
        aqWr_d        = accept ? aqWr_q + 1'b1 : aqWr_q;

        if (isBranching_i) begin
            fetchPC_d = maskPc(branchTarget_i, is64Bit_i);
            epoch_d   = ~epoch_q;
        end else if (accept) begin
            fetchPC_d = maskPc(fetchPC_q + addressWidth'(4), is64Bit_i);
        end

        if (isBranching_i && (outstanding_q != '0)) begin
            drainOld_d = 1'b1;
        end else if (outstanding_q == '0) begin
            drainOld_d = 1'b0;
        end

        if (accept && !respTake) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!accept && respTake) begin
            outstanding_d = outstanding_q - 1'b1;
        end

        if (isBranching_i) begin
            fifoRd_d    = '0;
            fifoWr_d    = '0;
            fifoCount_d = '0;
        end else begin
            fifoWr_d = push ? fifoWr_q + 1'b1 : fifoWr_q;
            fifoRd_d = pop ? fifoRd_q + 1'b1 : fifoRd_q;
            if (push && !pop) begin
                fifoCount_d = fifoCount_q + 1'b1;
            end else if (pop && !push) begin
                fifoCount_d = fifoCount_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fetchPC_q     <= resetVector;
            epoch_q       <= 1'b0;
            drainOld_q    <= 1'b0;
            outstanding_q <= '0;
            fifoCount_q   <= '0;
            fifoRd_q      <= '0;
            fifoWr_q      <= '0;
            aqRd_q        <= '0;
            aqWr_q        <= '0;
        end else begin
            fetchPC_q     <= fetchPC_d;
            epoch_q       <= epoch_d;
            drainOld_q    <= drainOld_d;
            outstanding_q <= outstanding_d;
            fifoCount_q   <= fifoCount_d;
            fifoRd_q      <= fifoRd_d;
            fifoWr_q      <= fifoWr_d;
            aqRd_q        <= aqRd_d;
            aqWr_q        <= aqWr_d;
        end
    end

    // Storage only; occupancy is tracked by the pointers above.
    always_ff @(posedge clock_i) begin
        if (accept) begin
            aq_q[aqWr_q] <= fetchPC_q;
        end
        if (push) begin
            fifoData_q[fifoWr_q] <= memRespData_i;
            fifoAddr_q[fifoWr_q] <= aq_q[aqRd_q];
        end
    end

    assign memReqValid_o        = reqValid;
    assign memReqAddr_o         = fetchPC_q;
    assign memReqEpoch_o        = epoch_q;
    assign instrValid_o         = (fifoCount_q != '0);
    assign instruction_o        = instrValid_o ? fifoData_q[fifoRd_q] : '0;
    assign instructionAddress_o = instrValid_o ? fifoAddr_q[fifoRd_q] : '0;
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: a 1-cycle memory model feeds a scoreboard of expected
// {address, word} pairs; redirect targets come from a vector table.
module tb_fetch_redirect_unit;
    localparam int AW = 64;
    localparam int IW = 32;

    logic          clock_i = 1'b0;
    logic          reset_i, stall_i, isBranching_i, is64Bit_i;
    logic [AW-1:0] branchTarget_i;
    logic          memReqValid_o, memReqEpoch_o, memReqReady_i;
    logic [AW-1:0] memReqAddr_o;
    logic          memRespValid_i, memRespEpoch_i;
    logic [IW-1:0] memRespData_i;
    logic          instrValid_o;
    logic [IW-1:0] instruction_o;
    logic [AW-1:0] instructionAddress_o;

    always #5 clock_i = ~clock_i;

    fetch_redirect_unit #(
        .addressWidth(AW), .resetVector(64'd0), .instrWidth(IW), .fifoDepth(4)
    ) dut (
        .clock_i(clock_i), .reset_i(reset_i), .stall_i(stall_i),
        .isBranching_i(isBranching_i), .branchTarget_i(branchTarget_i), .is64Bit_i(is64Bit_i),
        .memReqValid_o(memReqValid_o), .memReqAddr_o(memReqAddr_o), .memReqEpoch_o(memReqEpoch_o),
        .memReqReady_i(memReqReady_i), .memRespValid_i(memRespValid_i),
        .memRespData_i(memRespData_i), .memRespEpoch_i(memRespEpoch_i),
        .instrValid_o(instrValid_o), .instruction_o(instruction_o),
        .instructionAddress_o(instructionAddress_o)
    );

    typedef struct { logic [AW-1:0] addr; logic epoch; int gen; } req_t;
    typedef struct { logic [AW-1:0] addr; logic [IW-1:0] data; } exp_t;
    typedef struct { logic [AW-1:0] tgt; logic wide; logic [AW-1:0] a0; logic [AW-1:0] a1; } vec_t;

    req_t memQ[$];
    exp_t sbQ[$];
    vec_t vecs[5];

    int            checks = 0;
    int            errors = 0;
    logic [AW-1:0] expPC;
    logic          expEpoch;
    int            gen = 0;
    logic          respEn, spurious;
    int            accCount = 0;
    int            popCount = 0;
    logic [AW-1:0] lastAccAddr, lastPopAddr;
    logic          lastAccEpoch;
    logic [15:0]   respSeq = 16'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [AW-1:0] mask(input logic [AW-1:0] pc, input logic wide);
        return wide ? pc : {32'h0, pc[31:0]};
    endfunction

    // One clock cycle; entered just after a falling edge with the control inputs already set.
    task automatic tick();
        if (spurious) begin
            memRespValid_i = 1'b1;
            memRespEpoch_i = expEpoch;
            memRespData_i  = 32'hBAD0BAD0;
        end else if (respEn && memQ.size() > 0) begin
            memRespValid_i = 1'b1;
            memRespEpoch_i = memQ[0].epoch;
            memRespData_i  = {respSeq, memQ[0].addr[15:0]};
        end else begin
            memRespValid_i = 1'b0;
            memRespEpoch_i = 1'b0;
            memRespData_i  = '0;
        end
        #1;
        check("instrValid", 64'(instrValid_o), 64'(sbQ.size() > 0));
        if (!instrValid_o) check("emptyWord", 64'(instruction_o), 64'd0);
        if (instrValid_o && !stall_i && sbQ.size() > 0) begin
            exp_t e;
            e = sbQ.pop_front();
            check("instrAddr", instructionAddress_o, e.addr);
            check("instrData", 64'(instruction_o), 64'(e.data));
            popCount++;
            lastPopAddr = instructionAddress_o;
        end
        if (reset_i || isBranching_i) check("reqBlocked", 64'(memReqValid_o), 64'd0);
        if (memRespValid_i && !spurious) begin
            req_t r;
            r = memQ.pop_front();
            if (r.gen == gen && !isBranching_i && !reset_i)
                sbQ.push_back('{r.addr, memRespData_i});
            respSeq++;
        end
        if (memReqValid_o && memReqReady_i) begin
            check("reqAddr", memReqAddr_o, expPC);
            check("reqEpoch", 64'(memReqEpoch_o), 64'(expEpoch));
            memQ.push_back('{memReqAddr_o, memReqEpoch_o, gen});
            accCount++;
            lastAccAddr  = memReqAddr_o;
            lastAccEpoch = memReqEpoch_o;
            expPC = mask(expPC + 64'd4, is64Bit_i);
        end
        if (reset_i) begin
            sbQ.delete();
            memQ.delete();
            expPC    = 64'd0;
            expEpoch = 1'b0;
            gen++;
        end else if (isBranching_i) begin
            sbQ.delete();
            expPC    = mask(branchTarget_i, is64Bit_i);
            expEpoch = ~expEpoch;
            gen++;
        end
        @(posedge clock_i);
        @(negedge clock_i);
    endtask

    task automatic do_reset(input int n);
        reset_i = 1'b1; isBranching_i = 1'b0; spurious = 1'b0;
        repeat (n) tick();
        reset_i = 1'b0;
    endtask

    task automatic redirect(input logic [AW-1:0] t);
        isBranching_i = 1'b1; branchTarget_i = t;
        tick();
        isBranching_i = 1'b0;
    endtask

    task automatic run_until_acc(input int n, input int budget);
        int s = accCount;
        for (int k = 0; k < budget && (accCount - s) < n; k++) tick();
        check("accTimeout", 64'((accCount - s) >= n), 64'd1);
    endtask

    task automatic run_until_pop(input int n, input int budget);
        int s = popCount;
        for (int k = 0; k < budget && (popCount - s) < n; k++) tick();
        check("popTimeout", 64'((popCount - s) >= n), 64'd1);
    endtask

    initial begin
        int s;
        vecs[0] = '{64'h0000_0000_0000_1000, 1'b1, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_1004};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0000_0000_FFFF_FFFC, 64'h0000_0000_0000_0000};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_0000};
        vecs[3] = '{64'h1234_5678_9ABC_DEF0, 1'b0, 64'h0000_0000_9ABC_DEF0, 64'h0000_0000_9ABC_DEF4};
        vecs[4] = '{64'h0000_0001_0000_0000, 1'b0, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0004};

        reset_i = 1'b1; stall_i = 1'b0; isBranching_i = 1'b0; branchTarget_i = '0;
        is64Bit_i = 1'b1; memReqReady_i = 1'b1; respEn = 1'b1; spurious = 1'b0;
        memRespValid_i = 1'b0; memRespEpoch_i = 1'b0; memRespData_i = '0;
        expPC = 64'd0; expEpoch = 1'b0;
        @(negedge clock_i);

        // Reset then free-running fetch.
        do_reset(2);
        #1;
        check("rstInstrValid", 64'(instrValid_o), 64'd0);
        check("rstReqAddr", memReqAddr_o, 64'd0);
        check("rstReqEpoch", 64'(memReqEpoch_o), 64'd0);
        s = popCount;
        repeat (12) tick();
        check("noGapPops", 64'(popCount - s), 64'd10);
        check("noGapLast", lastPopAddr, 64'h24);

        // Decode stalled: the credit cap stops fetch at four.
        do_reset(2);
        stall_i = 1'b1;
        s = accCount;
        repeat (10) tick();
        check("stallAccepts", 64'(accCount - s), 64'd4);
        #1 check("stallReqValid", 64'(memReqValid_o), 64'd0);
        stall_i = 1'b0;
        tick();
        stall_i = 1'b1;
        #1;
        check("afterPopValid", 64'(memReqValid_o), 64'd1);
        check("afterPopAddr", memReqAddr_o, 64'h10);
        tick();
        check("afterPopAccepts", 64'(accCount - s), 64'd5);

        // Redirect with two buffered and two in flight.
        do_reset(2);
        stall_i = 1'b1; respEn = 1'b0;
        run_until_acc(4, 10);
        memReqReady_i = 1'b0; respEn = 1'b1;
        repeat (2) tick();
        respEn = 1'b0;
        #1 check("preRedirBuffered", 64'(instrValid_o), 64'd1);
        redirect(64'h1000);
        #1 check("redirFlush", 64'(instrValid_o), 64'd0);
        stall_i = 1'b0; memReqReady_i = 1'b1; respEn = 1'b1;
        run_until_acc(1, 20);
        check("redirReqAddr", lastAccAddr, 64'h1000);
        check("redirReqEpoch", 64'(lastAccEpoch), 64'd1);
        run_until_pop(1, 20);
        check("redirFirstPop", lastPopAddr, 64'h1000);

        // Redirect target / masking table.
        for (int i = 0; i < 5; i++) begin
            is64Bit_i = vecs[i].wide;
            redirect(vecs[i].tgt);
            run_until_acc(1, 20);
            check("vecAddr0", lastAccAddr, vecs[i].a0);
            run_until_acc(1, 20);
            check("vecAddr1", lastAccAddr, vecs[i].a1);
        end
        is64Bit_i = 1'b1;

        // Matching-epoch response in the redirect cycle.
        do_reset(2);
        respEn = 1'b0;
        run_until_acc(1, 5);
        memReqReady_i = 1'b0; respEn = 1'b1;
        redirect(64'h2000);
        memReqReady_i = 1'b1;
        #1;
        check("simulReqValid", 64'(memReqValid_o), 64'd1);
        check("simulReqAddr", memReqAddr_o, 64'h2000);
        check("simulReqEpoch", 64'(memReqEpoch_o), 64'd1);
        run_until_pop(1, 10);
        check("simulFirstPop", lastPopAddr, 64'h2000);

        // Back-to-back redirects with old responses outstanding.
        do_reset(2);
        respEn = 1'b0;
        run_until_acc(2, 5);
        memReqReady_i = 1'b0;
        redirect(64'h4000);
        redirect(64'h5000);
        memReqReady_i = 1'b1; respEn = 1'b1;
        run_until_acc(1, 20);
        check("b2bReqAddr", lastAccAddr, 64'h5000);
        check("b2bReqEpoch", 64'(lastAccEpoch), 64'd0);
        run_until_pop(1, 20);
        check("b2bFirstPop", lastPopAddr, 64'h5000);

        // Response with nothing outstanding is ignored.
        do_reset(2);
        memReqReady_i = 1'b0; spurious = 1'b1;
        tick();
        spurious = 1'b0; memReqReady_i = 1'b1;
        run_until_pop(1, 10);
        check("spuriousFirstPop", lastPopAddr, 64'h0);

        // Reset mid-operation: two buffered, two in flight, epoch 1, nonzero PC.
        do_reset(2);
        stall_i = 1'b1; respEn = 1'b0;
        redirect(64'h3000);
        run_until_acc(4, 10);
        memReqReady_i = 1'b0; respEn = 1'b1;
        repeat (2) tick();
        respEn = 1'b0;
        #1 check("midBuffered", 64'(instrValid_o), 64'd1);
        reset_i = 1'b1;
        tick();
        #1;
        check("midRstInstrValid", 64'(instrValid_o), 64'd0);
        check("midRstReqValid", 64'(memReqValid_o), 64'd0);
        tick();
        reset_i = 1'b0; memReqReady_i = 1'b1;
        #1;
        check("postRstReqValid", 64'(memReqValid_o), 64'd1);
        check("postRstReqAddr", memReqAddr_o, 64'd0);
        check("postRstReqEpoch", 64'(memReqEpoch_o), 64'd0);
        stall_i = 1'b0; respEn = 1'b1;
        run_until_pop(2, 10);
        check("postRstSecondPop", lastPopAddr, 64'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
